// File: rtl/seq_decoder_pkg.sv
// Shared opcode/ALU encodings, FSM states and control bundles for the sequencer decoder.
package seq_decoder_pkg;

    localparam logic [5:0] OP_NOP  = 6'b111111;
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_MUL  = 6'b000100;
    localparam logic [5:0] OP_MULI = 6'b000101;
    localparam logic [5:0] OP_ADDS = 6'b000110;
    localparam logic [5:0] OP_BABS = 6'b000111;
    localparam logic [5:0] OP_BREL = 6'b001000;
    localparam logic [5:0] OP_SHOW = 6'b001001;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;

    typedef enum logic [1:0] {RUN, MUL_WAIT, BR_WAIT} state_t;

    // Static per-opcode controls as produced by the decode table.
    typedef struct packed {
        logic [2:0] alu;
        logic       imm;
        logic       w;
        logic       store;
        logic       disp;
        logic       is_mul;
        logic       is_br;
        logic       is_abs;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [2:0] alu;
        logic       pc_incr;
        logic       pc_abs;
        logic       pc_rel;
        logic       imm;
        logic       w;
        logic       store;
        logic       disp;
        logic       br_timeout;
        logic       illegal;
    } out_t;

endpackage

// File: rtl/seq_decoder_rom.sv
// Purely combinational opcode-to-control table used while the sequencer is in RUN.
module decode_rom
    import seq_decoder_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPW'(OP_NOP):  ;
            OPW'(OP_ADD):  begin ctrl.alu = ALU_ADD; ctrl.w = 1'b1; end
            OPW'(OP_ADDI): begin ctrl.alu = ALU_ADD; ctrl.w = 1'b1; ctrl.imm = 1'b1; end
            OPW'(OP_SUB):  begin ctrl.alu = ALU_SUB; ctrl.w = 1'b1; end
            OPW'(OP_SUBI): begin ctrl.alu = ALU_SUB; ctrl.w = 1'b1; ctrl.imm = 1'b1; end
            OPW'(OP_ADDS): begin ctrl.alu = ALU_ADD; ctrl.w = 1'b1; ctrl.store = 1'b1; end
            OPW'(OP_MUL):  begin ctrl.alu = ALU_MUL; ctrl.w = 1'b1; ctrl.is_mul = 1'b1; end
            OPW'(OP_MULI): begin
                ctrl.alu = ALU_MUL; ctrl.w = 1'b1; ctrl.imm = 1'b1; ctrl.is_mul = 1'b1;
            end
            OPW'(OP_BABS): begin ctrl.is_br = 1'b1; ctrl.is_abs = 1'b1; end
            OPW'(OP_BREL): ctrl.is_br = 1'b1;
            OPW'(OP_SHOW): ctrl.disp = 1'b1;
            default:       ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_decoder.sv
// Instruction sequencer decoder: single-cycle ALU ops, multi-cycle multiply and
// branch-wait with timeout. Outputs are Mealy on the current opcode and gated by reset.
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int OPW        = 6,
    parameter int AFW        = 3,
    parameter int MUL_LAT    = 3,
    parameter int BR_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [3:0]     flags,
    input  logic           ready,
    input  logic           branch_cond,
    output logic           pc_incr,
    output logic           pc_abs,
    output logic           pc_rel,
    output logic [AFW-1:0] alu_func,
    output logic           imm,
    output logic           w,
    output logic           store,
    output logic           disp,
    output logic           stall,
    output logic           br_timeout,
    output logic           illegal
);

    localparam bit         MUL_MULTI = (MUL_LAT > 1);
    localparam logic [7:0] MUL_LOAD  = 8'(MUL_LAT - 1);
    // The RUN cycle that detects the mismatch counts as the first wait cycle.
    localparam logic [7:0] BR_LAST   = 8'((BR_TIMEOUT > 2) ? BR_TIMEOUT - 2 : 0);

    state_t         state, state_nx;
    logic [7:0]     cnt, cnt_nx;
    logic [OPW-1:0] op_q, op_nx;
    ctrl_t          rc;
    out_t           o;
    logic           br_match;
    logic           unused_flags;

    assign unused_flags = ^flags;
    assign br_match     = (ready == branch_cond);

    decode_rom #(.OPW(OPW)) u_rom (.opcode(opcode), .ctrl(rc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            op_q  <= OPW'(OP_NOP);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        o        = '0;
        o.alu    = ALU_NOP;
        case (state)
            RUN: begin
                if (rc.is_mul && MUL_MULTI) begin
                    op_nx    = opcode;
                    cnt_nx   = MUL_LOAD;
                    state_nx = MUL_WAIT;
                    o.alu    = ALU_MUL;
                    o.imm    = rc.imm;
                end else if (rc.is_br) begin
                    if (br_match) begin
                        o.pc_abs = rc.is_abs;
                        o.pc_rel = !rc.is_abs;
                    end else begin
                        op_nx    = opcode;
                        cnt_nx   = '0;
                        state_nx = BR_WAIT;
                    end
                end else begin
                    o.alu     = rc.alu;
                    o.imm     = rc.imm;
                    o.w       = rc.w;
                    o.store   = rc.store;
                    o.disp    = rc.disp;
                    o.illegal = rc.illegal;
                    o.pc_incr = 1'b1;
                end
            end
            MUL_WAIT: begin
                o.alu = ALU_MUL;
                o.imm = (op_q == OPW'(OP_MULI));
                if (cnt <= 8'd1) begin
                    o.w       = 1'b1;
                    o.pc_incr = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = RUN;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            BR_WAIT: begin
                if (br_match) begin
                    o.pc_abs = (op_q == OPW'(OP_BABS));
                    o.pc_rel = (op_q != OPW'(OP_BABS));
                    state_nx = RUN;
                end else if (cnt >= BR_LAST) begin
                    o.pc_incr    = 1'b1;
                    o.br_timeout = 1'b1;
                    state_nx     = RUN;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    assign pc_incr    = !reset && o.pc_incr;
    assign pc_abs     = !reset && o.pc_abs;
    assign pc_rel     = !reset && o.pc_rel;
    assign alu_func   = reset ? '0 : AFW'(o.alu);
    assign imm        = !reset && o.imm;
    assign w          = !reset && o.w;
    assign store      = !reset && o.store;
    assign disp       = !reset && o.disp;
    assign br_timeout = !reset && o.br_timeout;
    assign illegal    = !reset && o.illegal;
    assign stall      = !reset && !(o.pc_incr || o.pc_abs || o.pc_rel);

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter OPW, default 6: opcode width.
REQ-003 Parameter AFW, default 3: ALU function width.
REQ-004 Parameter MUL_LAT, default 3, legal range 1..15: MUL/MULI latency in cycles.
REQ-005 Parameter BR_TIMEOUT, default 8, legal range 1..255: maximum branch-wait cycles.
REQ-006 Port clk, input, 1: clock.
REQ-007 Port reset, input, 1: async active-high reset.
REQ-008 Port opcode, input, OPW: top bits of the current instruction; stable while the PC is not advanced.
REQ-009 Port flags, input, 4: ALU flags {V,N,Z,C}.
REQ-010 Port ready, input, 1: branch status (switch).
REQ-011 Port branch_cond, input, 1: required branch status (switch).
REQ-012 Outputs pc_incr, pc_abs, pc_rel, 1 each: PC controls, at most one high per cycle.
REQ-013 Output alu_func, AFW: ALU operation.
REQ-014 Outputs imm, w, store, disp, 1 each: immediate MUX select, register write, ALU-flag store, display strobe.
REQ-015 Output stall, 1: high in any cycle where no PC control is asserted.
REQ-016 Output br_timeout, 1: one-cycle pulse when a branch wait expires.
REQ-017 Output illegal, 1: one-cycle pulse on an undefined opcode.

Function
REQ-018 FSM states: RUN, MUL_WAIT, BR_WAIT.
REQ-019 RUN, ALU ops (ADD, ADDI, ADDS, SUB, SUBI): single cycle; w=1; pc_incr=1; imm=1 for *I forms only; store=1 for ADDS only; alu_func from the package table.
REQ-020 RUN, NOP: pc_incr=1; every other output 0.
REQ-021 RUN, SHOW: disp=1, pc_incr=1, w=0.
REQ-022 RUN, undefined opcode: behaves as NOP and additionally pulses illegal.
REQ-023 MUL/MULI with MUL_LAT=1: behaves as an ALU op in RUN.
REQ-024 MUL/MULI with MUL_LAT>1: latch the opcode, load the counter with MUL_LAT-1, enter MUL_WAIT with w=0 and stall=1.
REQ-025 MUL_WAIT: alu_func=MUL and imm are held from the latched opcode; the counter decrements each cycle.
REQ-026 MUL_WAIT, counter reaching 0: w=1 and pc_incr=1 for exactly that cycle, then return to RUN; total latency is MUL_LAT cycles.
REQ-027 RUN, BREL/BABS with ready==branch_cond: pc_rel (BREL) or pc_abs (BABS) asserted for 1 cycle; FSM stays in RUN.
REQ-028 RUN, BREL/BABS with ready!=branch_cond: latch the opcode, clear the wait counter, enter BR_WAIT with stall=1.
REQ-029 BR_WAIT: on the first cycle with ready==branch_cond, assert the latched branch's PC control, then return to RUN.
REQ-030 BR_WAIT: if no match within BR_TIMEOUT cycles, assert pc_incr (fall-through) and br_timeout in that cycle, then return to RUN.
REQ-031 BR_WAIT: a match in the same cycle the counter expires SHALL take the branch; br_timeout stays 0.
REQ-032 Counters SHALL saturate/stop on exit and SHALL never wrap.
REQ-033 flags SHALL be ignored in this version; the port is reserved.

Reset
REQ-034 While reset is high: state=RUN, counters=0, latched opcode=NOP, every output forced to 0, including pc_incr.
REQ-035 Reset asserted mid-MUL_WAIT or mid-BR_WAIT SHALL abort the operation; no w or PC pulse is emitted.
REQ-036 Decoding SHALL resume on the first clock edge after reset is released.

Structure
REQ-037 A shared package SHALL hold the opcode constants (NOP=111111, ADD=000000, ADDI=000001, SUB=000010, SUBI=000011, MUL=000100, MULI=000101, ADDS=000110, BABS=000111, BREL=001000, SHOW=001001), the ALU codes (NOP=000, ADD=001, SUB=010, MUL=011) and the state enum.
REQ-038 One sub-module, decode_rom, SHALL hold the purely combinational opcode-to-control table used in RUN.

Verification
REQ-039 Reset, then ADD: next cycle w=1, pc_incr=1, alu_func=001, imm=0, stall=0.
REQ-040 MULI with MUL_LAT=3: cycles 1-2 stall=1, w=0, imm=1; cycle 3 w=1, pc_incr=1; cycle 4 back in RUN.
REQ-041 BREL with ready=0, branch_cond=0: pc_rel=1 in a single cycle; then ready=0, branch_cond=1, ready raised at wait cycle 2 -> stall for 2 cycles, then pc_rel=1.
REQ-042 BABS with a permanent mismatch, BR_TIMEOUT=8: stall=1 for 7 cycles; cycle 8 pc_incr=1, br_timeout=1, pc_abs=0.
REQ-043 Opcode 101010 -> illegal=1 for 1 cycle, pc_incr=1, w=0.
REQ-044 Reset asserted at MUL_WAIT cycle 2 -> every output 0 immediately; after release, SHOW -> disp=1, pc_incr=1.
